// File: rtl/synth_pkg.sv
// Shared types and constants for the synthesizer audio path.
package synth_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      GAP
   } dac_state_t;

   localparam logic [3:0]  DAC_CFG_BITS = 4'b0011;
   localparam int unsigned DAC_FRAME_W  = 16;
   localparam int unsigned CH_W         = 11;
   localparam int unsigned CODE_W       = 12;
   localparam int unsigned MIX_W        = 13;

   // Scales the raw channel sum to the 12-bit DAC code for the given channel count.
   function automatic logic [CODE_W-1:0] mix_scale(input logic [MIX_W-1:0] sum,
                                                   input int unsigned       nch);
      logic [CODE_W-1:0] code;
      case (nch)
         1:       code = {sum[CH_W-1:0], 1'b0};
         2:       code = sum[CODE_W-1:0];
         default: code = sum[CODE_W:1];
      endcase
      return code;
   endfunction

endpackage

// File: rtl/dac_spi_tx.sv
// SPI framer for an MCP4921-class DAC: one 16-bit word per start pulse, MSB first.
module dac_spi_tx
   import synth_pkg::*;
#(
   parameter int unsigned SCK_DIV = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [DAC_FRAME_W-1:0] word,
   output logic                   busy,
   output logic                   dac_cs_n,
   output logic                   dac_sck,
   output logic                   dac_sdi
);

   localparam int unsigned    HW        = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam logic [HW-1:0]  HALF_LAST = HW'(SCK_DIV - 1);

   dac_state_t             state_q, state_d;
   logic [DAC_FRAME_W-1:0] shreg_q, shreg_d;
   logic [HW-1:0]          half_q, half_d;
   logic [3:0]             bit_q, bit_d;
   logic                   cs_n_q, cs_n_d;
   logic                   sck_q, sck_d;
   logic                   busy_q, busy_d;
   logic                   half_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         half_q  <= '0;
         bit_q   <= '0;
         cs_n_q  <= 1'b1;
         sck_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         half_q  <= half_d;
         bit_q   <= bit_d;
         cs_n_q  <= cs_n_d;
         sck_q   <= sck_d;
         busy_q  <= busy_d;
      end
   end

   assign half_end = (half_q == HALF_LAST);

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      half_d  = half_q;
      bit_d   = bit_q;
      cs_n_d  = cs_n_q;
      sck_d   = sck_q;
      busy_d  = busy_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               shreg_d = word;
               cs_n_d  = 1'b0;
               sck_d   = 1'b0;
               busy_d  = 1'b1;
               half_d  = '0;
               bit_d   = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d = SHIFT;
         end
         SHIFT: begin
            half_d = half_q + 1'b1;
            if (half_end) begin
               half_d = '0;
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  // Data advances on the falling SCK edge so it is stable across the next rise.
                  sck_d = 1'b0;
                  if (bit_q == 4'd15) begin
                     cs_n_d  = 1'b1;
                     shreg_d = '0;
                     state_d = GAP;
                  end else begin
                     bit_d   = bit_q + 1'b1;
                     shreg_d = {shreg_q[DAC_FRAME_W-2:0], 1'b0};
                  end
               end
            end
         end
         GAP: begin
            half_d = half_q + 1'b1;
            if (half_end) begin
               half_d  = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy     = busy_q;
   assign dac_cs_n = cs_n_q;
   assign dac_sck  = sck_q;
   assign dac_sdi  = shreg_q[DAC_FRAME_W-1];

endmodule

// File: rtl/dac_mixer.sv
// Channel mixer and sample-rate timebase feeding the external SPI DAC.
module dac_mixer
   import synth_pkg::*;
#(
   parameter int unsigned NCH        = 2,
   parameter int unsigned SAMPLE_DIV = 250,
   parameter int unsigned SCK_DIV    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NCH-1:0][CH_W-1:0]  ch_in,
   output logic                      dac_cs_n,
   output logic                      dac_sck,
   output logic                      dac_sdi,
   output logic                      busy,
   output logic                      sample_tick,
   output logic                      overrun
);

   localparam int unsigned CW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned SUM_W = CH_W + $clog2(NCH);

   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   tick;
   logic                   spi_busy;
   logic                   start;
   logic [SUM_W-1:0]       sum;
   logic [CODE_W-1:0]      code;
   logic [DAC_FRAME_W-1:0] frame;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      tick  = (cnt_q == CW'(SAMPLE_DIV - 1));
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_comb begin
      sum = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         sum = sum + SUM_W'(ch_in[i]);
      end
   end

   assign code  = mix_scale(MIX_W'(sum), NCH);
   assign frame = {DAC_CFG_BITS, code};

   // A tick landing mid-frame is reported and dropped; ch_in is not captured for it.
   assign start       = tick & ~spi_busy;
   assign overrun     = tick & spi_busy;
   assign sample_tick = tick;
   assign busy        = spi_busy;

   dac_spi_tx #(
      .SCK_DIV (SCK_DIV)
   ) u_spi (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .word     (frame),
      .busy     (spi_busy),
      .dac_cs_n (dac_cs_n),
      .dac_sck  (dac_sck),
      .dac_sdi  (dac_sdi)
   );

endmodule

// File: tb/tb_dac_mixer.sv
// Scoreboard bench for dac_mixer: four instances cover NCH=2/4/1 and a forced-overrun timebase.
module tb_dac_mixer;

   typedef struct packed {
      logic [15:0] word;
      logic        abort;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_o;
   logic [1:0][10:0] ch_a;
   logic [3:0][10:0] ch_4;
   logic [0:0][10:0] ch_1;
   logic [1:0][10:0] ch_o;
   logic [3:0] cs_n_w, sck_w, sdi_w, busy_w, tick_w, ovr_w;

   int checks = 0;
   int errors = 0;
   logic go = 1'b0, done_b = 1'b0, done_o = 1'b0;

   exp_t q0[$], q1[$], q2[$], q3[$];

   // index 0: NCH=2 default, 1: NCH=4, 2: NCH=1, 3: SAMPLE_DIV=40 (overrun)
   dac_mixer #(.NCH(2)) u_dut_a (
      .clk(clk), .rst(rst_a), .ch_in(ch_a),
      .dac_cs_n(cs_n_w[0]), .dac_sck(sck_w[0]), .dac_sdi(sdi_w[0]),
      .busy(busy_w[0]), .sample_tick(tick_w[0]), .overrun(ovr_w[0]));

   dac_mixer #(.NCH(4)) u_dut_4 (
      .clk(clk), .rst(rst_b), .ch_in(ch_4),
      .dac_cs_n(cs_n_w[1]), .dac_sck(sck_w[1]), .dac_sdi(sdi_w[1]),
      .busy(busy_w[1]), .sample_tick(tick_w[1]), .overrun(ovr_w[1]));

   dac_mixer #(.NCH(1)) u_dut_1 (
      .clk(clk), .rst(rst_b), .ch_in(ch_1),
      .dac_cs_n(cs_n_w[2]), .dac_sck(sck_w[2]), .dac_sdi(sdi_w[2]),
      .busy(busy_w[2]), .sample_tick(tick_w[2]), .overrun(ovr_w[2]));

   dac_mixer #(.NCH(2), .SAMPLE_DIV(40), .SCK_DIV(2)) u_dut_o (
      .clk(clk), .rst(rst_o), .ch_in(ch_o),
      .dac_cs_n(cs_n_w[3]), .dac_sck(sck_w[3]), .dac_sdi(sdi_w[3]),
      .busy(busy_w[3]), .sample_tick(tick_w[3]), .overrun(ovr_w[3]));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic push_exp(input int idx, input logic [15:0] w, input logic ab);
      exp_t e;
      e.word  = w;
      e.abort = ab;
      case (idx)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endtask

   task automatic pop_exp(input int idx, output exp_t e, output bit ok);
      e  = '0;
      ok = 1'b0;
      case (idx)
         0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
         2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
         default: if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
      endcase
   endtask

   task automatic wait_tick(input int idx, input int limit);
      int n;
      n = 0;
      @(negedge clk);
      while (tick_w[idx] !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (tick_w[idx] !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL tick_timeout[%0d]: no sample_tick within %0d cycles, required one", idx, limit);
      end
   endtask

   // SPI monitor: captures each frame on rising SCK and scores it at the CS rising edge.
   logic [3:0]  prev_cs  = '1;
   logic [3:0]  prev_sck = '0;
   logic [15:0] cap   [4];
   int          edges [4];
   int          cslen [4];

   always @(negedge clk) begin
      for (int g = 0; g < 4; g++) begin
         exp_t e;
         bit   ok;
         if (prev_cs[g] === 1'b1 && cs_n_w[g] === 1'b0) begin
            cap[g]   = '0;
            edges[g] = 0;
            cslen[g] = 1;
         end else if (cs_n_w[g] === 1'b0) begin
            cslen[g]++;
         end
         if (cs_n_w[g] === 1'b0 && prev_sck[g] === 1'b0 && sck_w[g] === 1'b1) begin
            cap[g] = {cap[g][14:0], sdi_w[g]};
            edges[g]++;
         end
         if (prev_cs[g] === 1'b0 && cs_n_w[g] === 1'b1) begin
            pop_exp(g, e, ok);
            if (!ok) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame[%0d]: got frame %04h, required no frame", g, cap[g]);
            end else if (e.abort) begin
               check($sformatf("abort_partial[%0d]", g), 32'(edges[g] < 16), 32'd1);
            end else begin
               check($sformatf("frame_word[%0d]", g), 32'(cap[g]), 32'(e.word));
               check($sformatf("sck_rises[%0d]", g), 32'(edges[g]), 32'd16);
               check($sformatf("cs_low_len[%0d]", g), 32'(cslen[g]), 32'd65);
            end
         end
         prev_cs[g]  = cs_n_w[g];
         prev_sck[g] = sck_w[g];
      end
   end

   // Timebase monitor for the default instance: ticks at cycle 249 mod 250 after reset.
   int   cyc_a;
   int   last_tick_a = -100;
   logic prev_cs_a   = 1'b1;

   always @(posedge clk) cyc_a <= rst_a ? 0 : cyc_a + 1;

   always @(negedge clk) begin
      if (rst_a === 1'b0) begin
         if (tick_w[0] === 1'b1 || (cyc_a % 250) == 249) begin
            check("tick_period_a", 32'(tick_w[0]), 32'((cyc_a % 250) == 249));
            check("overrun_a", 32'(ovr_w[0]), 32'd0);
            last_tick_a = cyc_a;
         end
         if (prev_cs_a === 1'b1 && cs_n_w[0] === 1'b0)
            check("cs_fall_after_tick_a", 32'(cyc_a), 32'(last_tick_a + 1));
      end
      prev_cs_a = cs_n_w[0];
   end

   // Overrun monitor: with SAMPLE_DIV=40 every odd tick lands inside a frame.
   int k_o = 0;
   always @(negedge clk) begin
      if (rst_o === 1'b0) begin
         if (tick_w[3] === 1'b1) begin
            check($sformatf("overrun_tick%0d_o", k_o), 32'(ovr_w[3]), 32'(k_o % 2));
            k_o++;
         end else if (ovr_w[3] !== 1'b0) begin
            check("overrun_without_tick_o", 32'(ovr_w[3]), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

   // Main stimulus: default instance, plus release of the others.
   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_o = 1'b1;
      ch_a = '0; ch_4 = '0; ch_1 = '0; ch_o = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cs_n", 32'(cs_n_w[0]), 32'd1);
      check("rst_sck", 32'(sck_w[0]), 32'd0);
      check("rst_sdi", 32'(sdi_w[0]), 32'd0);
      check("rst_busy", 32'(busy_w[0]), 32'd0);
      check("rst_tick", 32'(tick_w[0]), 32'd0);
      check("rst_overrun", 32'(ovr_w[0]), 32'd0);

      ch_a = {11'h3FF, 11'h400};
      push_exp(0, 16'h37FF, 1'b0);
      ch_4 = {4{11'h7FF}};
      push_exp(1, 16'h3FFE, 1'b0);          // 4*7FF = 1FFC, bits [12:1] = FFE
      ch_1 = 11'h001;
      push_exp(2, 16'h3002, 1'b0);
      ch_o = {11'h100, 11'h023};
      push_exp(3, 16'h3123, 1'b0);
      push_exp(3, 16'h3003, 1'b0);
      push_exp(3, 16'h35FF, 1'b0);
      push_exp(3, 16'h3001, 1'b0);

      @(posedge clk); #1;
      rst_a = 1'b0; rst_b = 1'b0; rst_o = 1'b0;
      go = 1'b1;

      wait_tick(0, 300);
      @(posedge clk); #1;
      ch_a = '0;
      push_exp(0, 16'h3000, 1'b0);

      wait_tick(0, 300);
      @(posedge clk); #1;
      ch_a = {11'h7FF, 11'h7FF};
      push_exp(0, 16'h3FFE, 1'b0);

      wait_tick(0, 300);
      @(posedge clk); #1;
      ch_a = {11'h123, 11'h456};
      push_exp(0, 16'h3579, 1'b1);

      wait_tick(0, 300);
      repeat (35) @(posedge clk);
      #1;
      check("cs_low_before_abort", 32'(cs_n_w[0]), 32'd0);
      rst_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_cs_n", 32'(cs_n_w[0]), 32'd1);
      check("abort_sck", 32'(sck_w[0]), 32'd0);
      check("abort_busy", 32'(busy_w[0]), 32'd0);
      @(posedge clk);
      @(posedge clk); #1;
      ch_a = {11'h001, 11'h7FF};
      push_exp(0, 16'h3800, 1'b0);
      rst_a = 1'b0;

      wait_tick(0, 300);
      repeat (80) @(posedge clk);

      wait (done_b && done_o);
      check("leftover_q0", 32'(q0.size()), 32'd0);
      check("leftover_q1", 32'(q1.size()), 32'd0);
      check("leftover_q2", 32'(q2.size()), 32'd0);
      check("leftover_q3", 32'(q3.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Scaling instances: one frame each, then parked in reset.
   initial begin
      wait (go);
      wait_tick(1, 300);
      repeat (80) @(posedge clk);
      #1;
      rst_b = 1'b1;
      done_b = 1'b1;
   end

   // Overrun instance: inputs change after every tick; only even ticks are captured.
   logic [1:0][10:0] ch_tab [8];
   initial begin
      ch_tab[0] = {11'h100, 11'h023};
      ch_tab[1] = {11'h7FF, 11'h7FF};
      ch_tab[2] = {11'h001, 11'h002};
      ch_tab[3] = {11'h200, 11'h200};
      ch_tab[4] = {11'h555, 11'h0AA};
      ch_tab[5] = {11'h7FF, 11'h001};
      ch_tab[6] = {11'h000, 11'h001};
      ch_tab[7] = {11'h3FF, 11'h3FF};
      wait (go);
      for (int k = 0; k < 8; k++) begin
         wait_tick(3, 60);
         @(posedge clk); #1;
         if (k < 7) ch_o = ch_tab[k + 1];
      end
      repeat (28) @(posedge clk);
      #1;
      rst_o = 1'b1;
      done_o = 1'b1;
   end

endmodule
